// File: rtl/second_counter_pkg.sv
// Shared constants for the one-second tick counter: count width and default
// terminal value (100 cycles per "second" at the default setting).
package second_counter_pkg;

  localparam int unsigned CNT_W              = 7;
  localparam int          SECOND_CNT_DEFAULT = 99;
  localparam int          MAX_LEGAL_VAL      = 127;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when a terminal value fits the counter and gives a period >= 2.
  function automatic bit max_val_legal(input int val);
    return (val >= 1) && (val <= MAX_LEGAL_VAL);
  endfunction

endpackage : second_counter_pkg

// File: rtl/second_counter.sv
// Free-running "second" counter: counts 0..pMAX_VAL while enabled, wraps to 0,
// and decodes the last and next-to-last values of the period.
module second_counter
  import second_counter_pkg::*;
#(
  parameter int pSECOND_CNT_VALUE = SECOND_CNT_DEFAULT,
  parameter int pMAX_VAL          = pSECOND_CNT_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             last,
  output logic             pre_last
);

  // Terminal value and its predecessor at counter width.
  localparam cnt_t MAX_C     = cnt_t'(pMAX_VAL);
  localparam cnt_t PRE_MAX_C = cnt_t'(pMAX_VAL - 1);

  // An illegal terminal value would either never be reached or collapse the
  // period, so refuse to elaborate rather than build a silently wrong counter.
  if (!max_val_legal(pMAX_VAL)) begin : g_bad_max_val
    $error("second_counter: pMAX_VAL=%0d outside legal range 1..%0d",
           pMAX_VAL, MAX_LEGAL_VAL);
  end

  cnt_t count_q;
  cnt_t count_d;

  // Next-state: increment below the terminal value, otherwise wrap to 0.
  // Using ">=" also recovers from any out-of-range value on the next enable.
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (count_q < MAX_C) begin
        count_d = count_q + 7'd1;
      end else begin
        count_d = 7'd0;
      end
    end else begin
      count_d = count_q;
    end
  end

  // Counter register; synchronous reset wins over enable and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 7'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  // Decodes are purely from the count so they are valid regardless of en.
  assign last     = (count_q == MAX_C);
  assign pre_last = (count_q == PRE_MAX_C);

endmodule : second_counter

// File: tb/tb_second_counter.sv
// Self-checking bench: a default instance (terminal 99) and a pMAX_VAL=5
// instance share rst/en; each is compared every cycle against a model that
// counts enabled cycles since reset and reduces modulo the period.
module tb_second_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] count_a, count_b;
  logic       last_a, last_b, pre_last_a, pre_last_b;

  int tests  = 0;
  int errors = 0;

  // Model state: number of enabled edges since the last reset edge.
  int unsigned k_en = 0;

  localparam int MAX_A = 99;
  localparam int MAX_B = 5;

  always #5 clk = ~clk;

  second_counter dut_a (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .count    (count_a),
    .last     (last_a),
    .pre_last (pre_last_a)
  );

  second_counter #(.pMAX_VAL(MAX_B)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .count    (count_b),
    .last     (last_b),
    .pre_last (pre_last_b)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    tests++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advance one clock with current rst/en, then compare both instances.
  task automatic tick();
    int ea, eb;
    if (rst)     k_en = 0;
    else if (en) k_en = k_en + 1;
    ea = int'(k_en % (MAX_A + 1));
    eb = int'(k_en % (MAX_B + 1));
    @(posedge clk);
    @(negedge clk);
    check("count_a",    int'(count_a),    ea);
    check("last_a",     int'(last_a),     (ea == MAX_A) ? 1 : 0);
    check("pre_last_a", int'(pre_last_a), (ea == MAX_A - 1) ? 1 : 0);
    check("excl_a",     int'(last_a & pre_last_a), 0);
    check("count_b",    int'(count_b),    eb);
    check("last_b",     int'(last_b),     (eb == MAX_B) ? 1 : 0);
    check("pre_last_b", int'(pre_last_b), (eb == MAX_B - 1) ? 1 : 0);
  endtask

  task automatic run_to(input int target);
    int guard = 0;
    rst = 1'b0;
    en  = 1'b1;
    while (int'(count_a) != target && guard < 200) begin
      tick();
      guard++;
    end
    check("run_to_reached", int'(count_a), target);
  endtask

  initial begin
    int per_cnt;
    // Initial reset from unknown state.
    rst = 1'b1; en = 1'b1;
    tick();
    check("reset_count", int'(count_a), 0);

    // Reset mid-count at 57, held two cycles with en high.
    run_to(57);
    rst = 1'b1; en = 1'b1;
    tick();
    check("rst57_count", int'(count_a), 0);
    check("rst57_last", int'(last_a), 0);
    check("rst57_pre", int'(pre_last_a), 0);
    tick();

    // Full run of 110 cycles from 0; count periods on dut_b too.
    rst = 1'b0; en = 1'b1;
    per_cnt = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (last_b) per_cnt++;
    end
    check("full_run_end", int'(count_a), 10);
    check("b_periods", per_cnt, 110 / 6);

    // Wrap at terminal value.
    run_to(99);
    check("at99_last", int'(last_a), 1);
    tick();
    check("wrap_count", int'(count_a), 0);
    check("wrap_last", int'(last_a), 0);

    // Hold at 42 for 5 cycles, then resume.
    run_to(42);
    en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("hold42", int'(count_a), 42);
    en = 1'b1;
    tick();
    check("resume43", int'(count_a), 43);

    // Reset on the terminal edge wins over wrap.
    run_to(99);
    rst = 1'b1; en = 1'b1;
    tick();
    check("rst_at_term", int'(count_a), 0);
    rst = 1'b0; en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    check("resume_from0", int'(count_a), 1);

    // Randomized en with occasional reset.
    for (int i = 0; i < 2000; i++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_second_counter

// File: doc/second_counter.md
SECOND_COUNTER -- requirements
Module: second_counter

Interface
REQ-001 Parameter pSECOND_CNT_VALUE, default 99, nominal terminal count of one "second" period in clock cycles minus one.
REQ-002 Parameter pMAX_VAL, default pSECOND_CNT_VALUE, effective terminal value of count; legal range 1..127.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 Port en  input  1  count enable; active-high.
REQ-006 Port count  output  7  current counter value, unsigned.
REQ-007 Port last  output  1  high while count equals pMAX_VAL.
REQ-008 Port pre_last  output  1  high while count equals pMAX_VAL-1.

Function
REQ-009 count SHALL be a registered 7-bit up-counter ranging 0..pMAX_VAL.
REQ-010 On a rising clk edge with rst low and en high, count SHALL increment by 1 if count < pMAX_VAL, else load 0 (wrap).
REQ-011 On a rising clk edge with rst low and en low, count SHALL hold its value.
REQ-012 Period with en held high SHALL be exactly pMAX_VAL+1 cycles (100 cycles by default).
REQ-013 last SHALL be a combinational decode (count == pMAX_VAL), independent of en.
REQ-014 pre_last SHALL be a combinational decode (count == pMAX_VAL-1), independent of en.
REQ-015 last and pre_last SHALL never be high simultaneously; each is high for one cycle per period when en is continuously high.
REQ-016 If count ever holds a value > pMAX_VAL, the next enabled edge SHALL load 0.
REQ-017 Outputs SHALL never be X after the first reset edge.
REQ-018 A parameter-check assertion SHALL flag pMAX_VAL < 1 or pMAX_VAL > 127 at elaboration.

Reset
REQ-019 With rst high at a rising clk edge, count SHALL load 0 regardless of en; last=0, pre_last=0 (pre_last=1 only if pMAX_VAL=1).
REQ-020 Reset SHALL take priority over en and wrap, including mid-count and at the terminal value.
REQ-021 After rst deasserts, counting SHALL resume from 0 on the first edge with en high.

Structure
REQ-022 A shared package SHALL hold the count width constant (7) and the default terminal value (99).
REQ-023 Single flat module; no sub-module is required (counter register plus two comparators).

Verification
REQ-024 Reset: rst=1 for 2 cycles with en=1, count=57 -> count=0, last=0, pre_last=0 after the first reset edge.
REQ-025 Full run: rst=0, en=1 for 110 cycles from 0 -> count 0,1,...,99,0,1,...,9; pre_last high only at count=98, last high only at count=99.
REQ-026 Wrap: count=99, en=1 -> next edge count=0, last drops to 0.
REQ-027 Hold: en=0 for 5 cycles at count=42 -> count stays 42; en=1 resumes to 43.
REQ-028 Reset at terminal: count=99, rst=1 and en=1 on same edge -> count=0.
REQ-029 Parameter override pMAX_VAL=5, en=1 -> count 0..5 repeating, period 6 cycles, pre_last at 4, last at 5.
